// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_arbiter
// Purpose  : Shares the register file's single read mux among NUM_REQ
//            requesters. Round-robin arbitration with valid/ready handshakes;
//            the granted address drives the mux select and the mux output is
//            captured into a one-entry response slot tagged with the ID of
//            the requester that was served.
// Ports    : clk, reset       - clock (rising edge), async active-high reset
//            req_valid/ready  - per-requester handshake (ready is one-hot)
//            req_addr         - packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//            mux_sel/mux_data - select to, and data from, the register read mux
//            rsp_valid/ready  - response slot handshake
//            rsp_id/rsp_data  - requester index and read data of the response
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int ZERO_REG = 1,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         mux_sel,
    input  logic [DATA_W-1:0]         mux_data,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic                      rsp_ready
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t             state;
    slot_t             state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic              any_valid;
    logic              can_accept;
    logic              accept;
    logic              addr_is_zero_reg;
    int                idx;

    // Round-robin scan starting at rr_ptr; the first valid requester wins.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid && req_valid[idx[ID_W-1:0]]) begin
                any_valid = 1'b1;
                winner    = idx[ID_W-1:0];
            end
        end
    end

    // The slot can take a new entry when empty or when it drains this cycle.
    assign can_accept = (state == EMPTY) || rsp_ready;
    assign accept     = any_valid && can_accept;

    // Select is driven even when the grant is blocked so mux_data has already
    // settled by the cycle in which acceptance finally happens.
    assign mux_sel = any_valid ? req_addr[winner*ADDR_W +: ADDR_W] : '0;

    assign addr_is_zero_reg = (ZERO_REG != 0) && (mux_sel == {ADDR_W{1'b1}});

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Slot FSM: next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (any_valid) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (rsp_ready) begin
                    state_nxt = any_valid ? FULL : EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Response payload and round-robin pointer move only on an accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_id   <= '0;
            rsp_data <= '0;
            rr_ptr   <= '0;
        end else if (accept) begin
            rsp_id   <= winner;
            rsp_data <= addr_is_zero_reg ? '0 : mux_data;
            rr_ptr   <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Registered-only path: rsp_valid never depends on rsp_ready combinationally.
    assign rsp_valid = (state == FULL);

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_read_arbiter
// Purpose  : Self-checking bench for regfile_read_arbiter. Two instances share
//            the requester stimulus: one with the zero register enabled, one
//            with it disabled. A behavioural model predicts grants, select and
//            the response stream; directed vectors pin key values literally.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_read_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic                      rsp_ready;

    logic [NUM_REQ-1:0] req_ready,  z0_req_ready;
    logic [ADDR_W-1:0]  mux_sel,    z0_mux_sel;
    logic [DATA_W-1:0]  mux_data,   z0_mux_data;
    logic               rsp_valid,  z0_rsp_valid;
    logic [ID_W-1:0]    rsp_id,     z0_rsp_id;
    logic [DATA_W-1:0]  rsp_data,   z0_rsp_data;

    logic [DATA_W-1:0] regs [32];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign mux_data    = regs[mux_sel];
    assign z0_mux_data = regs[z0_mux_sel];

    regfile_read_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .mux_sel(mux_sel), .mux_data(mux_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    regfile_read_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG(0)) dut_z0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(z0_req_ready), .mux_sel(z0_mux_sel), .mux_data(z0_mux_data),
        .rsp_valid(z0_rsp_valid), .rsp_id(z0_rsp_id), .rsp_data(z0_rsp_data), .rsp_ready(rsp_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
        req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [ADDR_W-1:0] addr_of(input int i);
        return req_addr[i*ADDR_W +: ADDR_W];
    endfunction

    // Round-robin rule: first valid requester at ptr, ptr+1, ... modulo NUM_REQ.
    function automatic void pick(input logic [NUM_REQ-1:0] v, input int ptr,
                                 output bit any, output int w);
        any = 1'b0;
        w   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (ptr + k) % NUM_REQ;
            if (!any && v[j]) begin
                any = 1'b1;
                w   = j;
            end
        end
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_full;
    int          m_id;
    logic [31:0] m_data;      // expected with the zero register enabled
    logic [31:0] m_data_raw;  // expected with the zero register disabled
    int          m_ptr;
    int          m_wait [NUM_REQ];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_full <= 1'b0;
            m_id   <= 0;
            m_data <= '0;
            m_data_raw <= '0;
            m_ptr  <= 0;
            for (int i = 0; i < NUM_REQ; i++) m_wait[i] <= 0;
        end else begin : model_step
            bit any;
            int w;
            logic [ADDR_W-1:0] a;
            pick(req_valid, m_ptr, any, w);
            if (any && (!m_full || rsp_ready)) begin
                a = addr_of(w);
                m_full     <= 1'b1;
                m_id       <= w;
                m_data     <= (a == 5'd31) ? 32'h0 : regs[a];
                m_data_raw <= regs[a];
                m_ptr      <= (w + 1) % NUM_REQ;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i == w || !req_valid[i]) m_wait[i] <= 0;
                    else                         m_wait[i] <= m_wait[i] + 1;
                end
            end else if (rsp_ready) begin
                m_full <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin : cmp
            bit any;
            int w;
            logic [NUM_REQ-1:0] exp_ready;
            logic [ADDR_W-1:0]  exp_sel;
            pick(req_valid, m_ptr, any, w);
            exp_ready = '0;
            if (any && (!m_full || rsp_ready)) exp_ready[w] = 1'b1;
            exp_sel = any ? addr_of(w) : '0;
            chk("req_ready",    32'(req_ready),    32'(exp_ready));
            chk("mux_sel",      32'(mux_sel),      32'(exp_sel));
            chk("onehot",       32'($onehot0(req_ready)), 32'd1);
            chk("rsp_valid",    32'(rsp_valid),    32'(m_full));
            chk("z0_rsp_valid", 32'(z0_rsp_valid), 32'(m_full));
            if (m_full) begin
                chk("rsp_id",      32'(rsp_id),    32'(m_id));
                chk("rsp_data",    rsp_data,       m_data);
                chk("z0_rsp_data", z0_rsp_data,    m_data_raw);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (m_wait[i] > NUM_REQ - 1) chk("fair_wait", 32'(m_wait[i]), 32'(NUM_REQ - 1));
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    logic [NUM_REQ-1:0] seen_ready;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hA5A5_0000 | 32'(i);
        regs[5]  = 32'hDEAD_BEEF;
        regs[31] = 32'hFFFF_FFFF;
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id",    32'(rsp_id),    32'd0);
        chk("rst_data",  rsp_data,       32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // 1: single read, same-cycle grant, one-cycle latency
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 4'b0001; set_addr(0, 5'd5); rsp_ready = 1'b1;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'b0001);
        chk("t1_sel",   32'(mux_sel),   32'd5);
        @(posedge clk); #1; req_valid = '0;
        @(negedge clk);
        chk("t1_rvalid", 32'(rsp_valid), 32'd1);
        chk("t1_rid",    32'(rsp_id),    32'd0);
        chk("t1_rdata",  rsp_data,       32'hDEAD_BEEF);

        // Return pointer to 0 before the fairness pattern
        @(posedge clk); #1; reset = 1'b1; #2; reset = 1'b0;

        // 2: all four valid for 8 cycles -> 0,1,2,3,0,1,2,3 back to back
        for (int i = 0; i < NUM_REQ; i++) set_addr(i, 5'(i + 1));
        req_valid = 4'b1111;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8) chk("t2_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (k > 0) begin
                chk("t2_rvalid", 32'(rsp_valid), 32'd1);
                chk("t2_rid",    32'(rsp_id),    32'((k - 1) % 4));
            end
            @(posedge clk); #1;
            if (k == 7) req_valid = '0;
        end

        // 3: full slot held by consumer back-pressure
        req_valid = 4'b0001; set_addr(0, 5'd7); rsp_ready = 1'b0;
        @(negedge clk);
        chk("t3_first", 32'(req_ready), 32'b0001);
        @(posedge clk); #1; req_valid = 4'b0010; set_addr(1, 5'd9);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_block", 32'(req_ready), 32'b0000);
            chk("t3_hid",   32'(rsp_id),    32'd0);
            chk("t3_hdata", rsp_data,       32'hA5A5_0007);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1; req_valid = '0;
        @(negedge clk);
        chk("t3_rid",   32'(rsp_id), 32'd1);
        chk("t3_rdata", rsp_data,    32'hA5A5_0009);

        // 4: zero register (pointer now at 2)
        @(posedge clk); #1; req_valid = 4'b0100; set_addr(2, 5'd31);
        @(negedge clk);
        chk("t4_ready", 32'(req_ready), 32'b0100);
        chk("t4_sel",   32'(mux_sel),   32'd31);
        @(posedge clk); #1; req_valid = '0;
        @(negedge clk);
        chk("t4_zero",  rsp_data,    32'h0);
        chk("t4_raw",   z0_rsp_data, 32'hFFFF_FFFF);

        // 5: async reset while holding a response with pointer at 2
        @(posedge clk); #1; req_valid = 4'b0010; set_addr(1, 5'd4);
        @(negedge clk);
        chk("t5_pre", 32'(req_ready), 32'b0010);
        @(posedge clk); #1; req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk);
        chk("t5_held", 32'(rsp_valid), 32'd1);
        #2;
        reset = 1'b1; req_valid = 4'b1010; set_addr(1, 5'd6); set_addr(3, 5'd8);
        #1;
        chk("t5_drop", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1; reset = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        chk("t5_req1", 32'(req_ready), 32'b0010);
        @(posedge clk); #1; req_valid = 4'b1000;
        @(negedge clk);
        chk("t5_req3",  32'(req_ready), 32'b1000);
        chk("t5_rid1",  32'(rsp_id),    32'd1);
        chk("t5_data1", rsp_data,       32'hA5A5_0006);
        @(posedge clk); #1; req_valid = '0;
        @(negedge clk);
        chk("t5_rid3",  32'(rsp_id),    32'd3);
        chk("t5_data3", rsp_data,       32'hA5A5_0008);

        // 6: random traffic obeying the hold-until-ready rule
        @(posedge clk); #1;
        repeat (10000) begin
            @(negedge clk);
            seen_ready = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || seen_ready[i]) begin
                    req_valid[i] = ($urandom_range(1) == 1);
                    set_addr(i, 5'($urandom_range(31)));
                end
            end
            rsp_ready = ($urandom_range(9) < 7);
        end
        req_valid = '0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
